// File: rtl/p_cache_ctrl_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
// The slave modport is the cache controller; master is the PC/memory environment.
interface p_cache_ctrl_if;
    logic [15:0] A;
    logic        flush;
    logic [15:0] I;
    logic        p_cache_miss;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_valid;

    modport slave (
        input  A, flush, mem_data, mem_valid,
        output I, p_cache_miss, mem_req, mem_addr
    );

    modport master (
        output A, flush, mem_data, mem_valid,
        input  I, p_cache_miss, mem_req, mem_addr
    );
endinterface

// File: rtl/p_cache_ctrl.sv
// Direct-mapped instruction cache controller: 1-cycle lookup on the sampled
// fetch address, line fill from memory on a miss with critical-word forwarding.
module p_cache_ctrl #(
    parameter int LINE_BITS   = 4,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_BITS    = 16 - LINE_BITS - OFFSET_BITS
) (
    input  logic          clk,
    input  logic          rst,
    p_cache_ctrl_if.slave bus
);

    localparam int LINES = 1 << LINE_BITS;
    localparam int WORDS = 1 << OFFSET_BITS;
    localparam int AW    = LINE_BITS + OFFSET_BITS;

    typedef enum logic {IDLE, FILL} state_t;

    state_t state, state_nxt;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [15:0]         data_mem [LINES*WORDS];

    logic [15:0]            a_q;
    logic                   a_vld;
    logic                   flush_q;
    logic [15:0]            miss_addr;
    logic [OFFSET_BITS-1:0] cnt;
    logic                   flush_pending;

    logic [TAG_BITS-1:0]    q_tag, m_tag;
    logic [LINE_BITS-1:0]   q_idx, m_idx;
    logic [OFFSET_BITS-1:0] m_off;

    logic lookup_hit, start_fill, fill_we, fill_last, flush_all;

    assign q_tag = a_q[15:AW];
    assign q_idx = a_q[AW-1:OFFSET_BITS];
    assign m_tag = miss_addr[15:AW];
    assign m_idx = miss_addr[AW-1:OFFSET_BITS];
    assign m_off = miss_addr[OFFSET_BITS-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_fill) state_nxt = FILL;
            FILL: if (fill_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // a_vld is only ever set while staying in IDLE, so it implies an IDLE lookup
    always_comb begin
        lookup_hit = a_vld && !flush_q && valid[q_idx] && (tag_mem[q_idx] == q_tag);
        start_fill = (state == IDLE) && a_vld && !lookup_hit;
        fill_we    = (state == FILL) && bus.mem_valid && bus.mem_req;
        fill_last  = fill_we && (&cnt);
        flush_all  = ((state == IDLE) && bus.flush) ||
                     (fill_last && (flush_pending || bus.flush));
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{m_idx, cnt}] <= bus.mem_data;
            if (fill_last) tag_mem[m_idx] <= m_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid            <= '0;
            a_q              <= '0;
            a_vld            <= 1'b0;
            flush_q          <= 1'b0;
            miss_addr        <= '0;
            cnt              <= '0;
            flush_pending    <= 1'b0;
            bus.I            <= '0;
            bus.p_cache_miss <= 1'b0;
            bus.mem_req      <= 1'b0;
            bus.mem_addr     <= '0;
        end else begin
            if (state == IDLE) a_q <= bus.A;
            a_vld   <= (state == IDLE) && !start_fill;
            flush_q <= (state == IDLE) && bus.flush;

            if (flush_all)      valid        <= '0;
            else if (fill_last) valid[m_idx] <= 1'b1;

            if (lookup_hit) bus.I <= data_mem[a_q[AW-1:0]];

            if (start_fill) begin
                miss_addr        <= a_q;
                bus.p_cache_miss <= 1'b1;
                bus.mem_req      <= 1'b1;
                bus.mem_addr     <= {a_q[15:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end

            if (fill_we) begin
                cnt <= fill_last ? '0 : cnt + 1'b1;
                if (cnt == m_off) bus.I <= bus.mem_data;
            end

            if (fill_last) begin
                bus.mem_req      <= 1'b0;
                bus.p_cache_miss <= 1'b0;
            end

            if (state == FILL)
                flush_pending <= fill_last ? 1'b0 : (flush_pending | bus.flush);
        end
    end

endmodule

// File: doc/p_cache_ctrl.md
Name: p_cache_ctrl

Overview:
- Direct-mapped instruction cache controller. Answers the fetch addresses issued by the program counter.
- Returns one 16-bit instruction per cycle on a hit.
- On a miss, raises p_cache_miss and stalls the fetch side while it fills a line from the SDRAM arbiter over a request/burst-data interface.
- Sits between the PC fetch-address output and the memory controller.

Parameters:
LINE_BITS, 4, log2 of number of cache lines (16 lines)
OFFSET_BITS, 2, log2 of 16-bit words per line (4 words)
TAG_BITS, 10, 16 - LINE_BITS - OFFSET_BITS

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
A  input  16  fetch address from PC, sampled every cycle in IDLE
flush  input  1  invalidate all lines
I  output  16  instruction for the address sampled on the previous edge
p_cache_miss  output  1  registered; high while a line fill is pending
mem_req  output  1  line-fill request to memory
mem_addr  output  16  line base address {miss_tag, miss_index, OFFSET_BITS zeros}
mem_data  input  16  fill data word
mem_valid  input  1  mem_data valid; words arrive in ascending offset order

Behaviour:
- Reset (rst=0, async):
  - All valid bits clear; state IDLE; word counter 0; flush_pending 0.
  - I=16'h0000, p_cache_miss=0, mem_req=0, mem_addr=16'h0000.
  - Reset during a fill aborts it; the partially written line stays invalid.
- Storage:
  - Valid bits in flops, so they clear in one cycle.
  - Tag and data arrays may be synchronous-read RAM. The 1-cycle lookup latency below is mandatory either way.
- Address split: tag=A[15:LINE_BITS+OFFSET_BITS], index=A[LINE_BITS+OFFSET_BITS-1:OFFSET_BITS], offset=A[OFFSET_BITS-1:0].
- IDLE: edge N samples A; the lookup result is presented after edge N+1.
  - Hit (valid[index] and tag match, flush=0): I = data word at edge N+1; p_cache_miss=0. Back-to-back hits give 1 instruction per cycle.
  - Miss, or flush=1 in the sampling cycle:
    - Capture miss_addr=A.
    - At edge N+1: p_cache_miss=1, mem_req=1, mem_addr=line base. State -> FILL.
    - I holds its previous value.
    - On flush, all valid bits clear at the same edge, and the sampled address is treated as a miss.
- FILL:
  - A is ignored.
  - Each cycle with mem_valid=1: write mem_data to the line at offset=counter, then counter++.
  - When counter equals the miss offset, also load I<=mem_data (critical word).
  - mem_req stays high until the edge that accepts the last word (counter=2^OFFSET_BITS-1), then drops.
  - At that same edge:
    - Write the tag.
    - Set valid[index] unless flush_pending.
    - Clear counter; state -> IDLE; p_cache_miss -> 0.
  - The first IDLE cycle samples A again. The PC replays from its miss address, so the replayed fetch hits.
- flush during FILL: set flush_pending. At fill completion, clear all valid bits including the filled line, then clear flush_pending.
- mem_valid outside FILL is ignored. mem_valid with mem_req low is ignored.
- The counter wraps only through the explicit clear at the last word; no partial-line hits are ever reported.
- Simultaneous last-word and flush in the same cycle: the line is not validated.

Test Plan:
- Reset then A=16'h0000 for 1 cycle -> p_cache_miss=1 and mem_req=1 next cycle, mem_addr=16'h0000. Feed 16'h1111,2222,3333,4444 with mem_valid -> I=16'h1111 after the first word; p_cache_miss=0 and mem_req=0 after the fourth.
- After that fill, A=0001,0002,0003 on consecutive cycles -> I=2222,3333,4444 on consecutive cycles, p_cache_miss stays 0.
- Miss on A=16'h0046 (index 1, offset 2), words AAAA,BBBB,CCCC,DDDD with a 2-cycle gap between words -> mem_addr=16'h0044, I=CCCC after the third word, mem_req held through the gaps.
- Conflict: fill 16'h0000, then A=16'h0040 (same index, different tag) -> miss and refill. A=16'h0000 then misses again.
- flush asserted mid-fill -> fill completes and p_cache_miss drops. A re-fetch of the same address misses.
- rst=0 in the second word of a fill -> mem_req and p_cache_miss go to 0 immediately. After release, a fetch of that address misses.
